// File: rtl/cb_uart_rx.sv
// cb_uart_rx: 8N1 UART receiver with 16x oversampling and a single-entry holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and check even parity.
module cb_uart_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction
`endif

  logic          sync1_q, sync2_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_s;
  logic [3:0]    smp_q, smp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          deliver_s, pop_s;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign rx_s = sync2_q;

  // Line synchroniser, preset idle-high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Frame state, oversampling counters and shift register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      smp_q      <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit, checked together with the data at the stop bit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Next-state logic; ticks stay phase-locked to the start edge because the divider idles at 0
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver_s = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    tick_s = (state_q != S_IDLE) && (tick_cnt_q == DIV_M1);
    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
    if (tick_s) begin
      smp_d = smp_q + 4'd1;
    end else begin
      smp_d = smp_q;
    end

    case (state_q)
      S_IDLE: begin
        smp_d = 4'd0;
        bit_d = 3'd0;
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s && (smp_q == 4'd7)) begin
          smp_d = 4'd0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s && (smp_q == 4'd15)) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_s && (smp_q == 4'd15)) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (tick_s && (smp_q == 4'd15)) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT;
`ifdef UART_RX_PARITY_EN
          end else if (odd_parity({par_q, shift_q})) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            deliver_s = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Holding register: an ack in the delivery cycle frees the slot for the new byte
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    pop_s   = rx_ack && valid_q;
    if (deliver_s) begin
      if (!valid_q || pop_s) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (pop_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Registered consumer-facing outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = busy_q;

endmodule
